// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO edge-interrupt stage: pin count, register
// byte offsets, DEBOUNCE field positions, register-select decode and a
// byte-enable merge helper.
package gpio_pkg;

  localparam int unsigned NPINS = 16;
  localparam int unsigned PRE_W = 16;

  localparam logic [4:0] GPIO_IRQ_STATUS_OFS = 5'h00;
  localparam logic [4:0] GPIO_IRQ_EDGE_OFS   = 5'h04;
  localparam logic [4:0] GPIO_IRQ_DB_OFS     = 5'h08;
  localparam logic [4:0] GPIO_IRQ_PRE_OFS    = 5'h0C;

  // DEBOUNCE register field positions
  localparam int unsigned GPIO_IRQ_DB_MASK_LSB   = 0;
  localparam int unsigned GPIO_IRQ_DB_THRESH_LSB = 16;

  typedef enum logic [2:0] {
    RegStatus = 3'd0,
    RegEdge   = 3'd1,
    RegDb     = 3'd2,
    RegPre    = 3'd3,
    RegNone   = 3'd7
  } gpio_irq_reg_e;

  // idx is bus_addr[4:2]; the byte lane bits never take part in decode.
  function automatic gpio_irq_reg_e decode_reg(input logic [2:0] idx);
    logic [4:0] ofs;
    ofs = {idx, 2'b00};
    if (ofs == GPIO_IRQ_STATUS_OFS) return RegStatus;
    if (ofs == GPIO_IRQ_EDGE_OFS)   return RegEdge;
    if (ofs == GPIO_IRQ_DB_OFS)     return RegDb;
    if (ofs == GPIO_IRQ_PRE_OFS)    return RegPre;
    return RegNone;
  endfunction

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// Per-pin debounce: holds the clean level and a change counter. The clean
// level follows the synchronised input after it has differed for thresh_i
// consecutive ticks; with en_i low or thresh_i zero it follows every cycle.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   sync_i       synchronised pad value
//   tick_i       prescaler tick
//   en_i         debounce enable for this pin (DB_MASK bit)
//   thresh_i     number of ticks required (0 = bypass)
//   clean_o      conditioned level
module gpio_debounce_bit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             clean_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             clean_q, clean_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (!en_i || (thresh_i == '0)) begin
      clean_d = sync_i;
      cnt_d   = '0;
    end else if (sync_i == clean_q) begin
      // Any return to the clean level restarts the count.
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_inc == thresh_i) begin
        clean_d = sync_i;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/gpio_edge_irq.sv
// GPIO input conditioning and edge interrupt stage. Synchronises the 16 pads,
// optionally debounces them, presents clean levels, latches enabled rising /
// falling edges as pending bits and drives a registered level interrupt.
// Build option: define GPIO_IRQ_DEBOUNCE_EN to include the prescaler, the
// per-pin debounce counters and the DEBOUNCE / PRESCALE registers; otherwise
// every pin is bypassed and those offsets read 0.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   irq_ce_i         chip select
//   bus_we_i         byte write enables
//   bus_re_i         read enable
//   bus_wdata_i      write data
//   bus_addr_i       byte address, [4:2] selects the register
//   bus_rdata_o      read data, high-Z unless irq_ce_i & bus_re_i
//   gpio_in_i        raw pad values
//   gpio_in_clean_o  conditioned levels
//   irq_o            level interrupt (OR of pending, registered)
module gpio_edge_irq
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2, // must be >= 2
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 irq_ce_i,
  input  logic [3:0]           bus_we_i,
  input  logic                 bus_re_i,
  input  logic [31:0]          bus_wdata_i,
  input  logic [16:0]          bus_addr_i,
  output logic [31:0]          bus_rdata_o,
  input  logic [NPINS-1:0]     gpio_in_i,
  output logic [NPINS-1:0]     gpio_in_clean_o,
  output logic                 irq_o
);

  gpio_irq_reg_e reg_sel;
  logic          wr_en, rd_en;
  logic          unused_addr;

  assign reg_sel     = decode_reg(bus_addr_i[4:2]);
  assign wr_en       = irq_ce_i && (bus_we_i != 4'b0000);
  assign rd_en       = irq_ce_i && bus_re_i;
  // Upper address bits are decoded into irq_ce_i; byte lanes are ignored.
  assign unused_addr = ^{bus_addr_i[16:5], bus_addr_i[1:0]};

  // Synchroniser: stage 0 samples the pad, stage SYNC_STAGES-1 is used.
  logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
  logic [NPINS-1:0]                  sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  logic [NPINS-1:0] clean;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [NPINS-1:0] db_mask_q;
  logic [CNT_W-1:0] db_thresh_q;
  logic [PRE_W-1:0] prescale_q, pre_cnt_q;
  logic             tick;
  logic [31:0]      db_word, db_wr, pre_wr;
  logic             unused_wr;

  always_comb begin
    db_word = '0;
    db_word[GPIO_IRQ_DB_MASK_LSB +: NPINS]   = db_mask_q;
    db_word[GPIO_IRQ_DB_THRESH_LSB +: CNT_W] = db_thresh_q;
  end

  assign db_wr     = apply_be(db_word, bus_wdata_i, bus_we_i);
  assign pre_wr    = apply_be({{(32-PRE_W){1'b0}}, prescale_q}, bus_wdata_i, bus_we_i);
  assign unused_wr = ^{db_wr, pre_wr};
  assign tick      = (pre_cnt_q == prescale_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_mask_q   <= '0;
      db_thresh_q <= '0;
      prescale_q  <= '0;
      pre_cnt_q   <= '0;
    end else begin
      if (wr_en && (reg_sel == RegDb)) begin
        db_mask_q   <= db_wr[GPIO_IRQ_DB_MASK_LSB +: NPINS];
        db_thresh_q <= db_wr[GPIO_IRQ_DB_THRESH_LSB +: CNT_W];
      end
      // A PRESCALE write restarts the tick phase from zero.
      if (wr_en && (reg_sel == RegPre)) begin
        prescale_q <= pre_wr[PRE_W-1:0];
        pre_cnt_q  <= '0;
      end else if (tick) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_q + PRE_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NPINS; g++) begin : g_db
    gpio_debounce_bit #(
      .CNT_W (CNT_W)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_i   (sync[g]),
      .tick_i   (tick),
      .en_i     (db_mask_q[g]),
      .thresh_i (db_thresh_q),
      .clean_o  (clean[g])
    );
  end
`else
  logic [NPINS-1:0] clean_q;
  logic [CNT_W-1:0] unused_cnt_w;

  assign unused_cnt_w = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q <= '0;
    end else begin
      clean_q <= sync;
    end
  end

  assign clean = clean_q;
`endif

  assign gpio_in_clean_o = clean;

  // Edge detection and pending latch
  logic [NPINS-1:0] clean_dly_q, rise_en_q, fall_en_q, pending_q, pending_d;
  logic [NPINS-1:0] rise, fall, w1c;
  logic [31:0]      edge_wr;
  logic             irq_q;

  assign rise    = clean & ~clean_dly_q;
  assign fall    = ~clean & clean_dly_q;
  assign edge_wr = apply_be({fall_en_q, rise_en_q}, bus_wdata_i, bus_we_i);
  assign w1c     = (wr_en && (reg_sel == RegStatus)) ?
                   ({{8{bus_we_i[3]}}, {8{bus_we_i[2]}}} & bus_wdata_i[31:16]) : '0;
  // A new edge in the same cycle as its W1C keeps the bit set.
  assign pending_d = (pending_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);

  // Read mux
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      RegStatus: rdata_d = {pending_q, clean};
      RegEdge:   rdata_d = {fall_en_q, rise_en_q};
`ifdef GPIO_IRQ_DEBOUNCE_EN
      RegDb:     rdata_d = db_word;
      RegPre:    rdata_d = {{(32-PRE_W){1'b0}}, prescale_q};
`endif
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_dly_q <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      pending_q   <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      clean_dly_q <= clean;
      pending_q   <= pending_d;
      irq_q       <= |pending_q;
      if (wr_en && (reg_sel == RegEdge)) begin
        {fall_en_q, rise_en_q} <= edge_wr;
      end
      if (rd_en) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign irq_o       = irq_q;
  assign bus_rdata_o = rd_en ? rdata_q : 'z;

endmodule

// File: tb/tb_gpio_edge_irq.sv
module tb_gpio_edge_irq;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam bit DbOn = 1'b1;
`else
  localparam bit DbOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_ce = 1'b0;
  logic [3:0]  bus_we = '0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [16:0] bus_addr = '0;
  wire  [31:0] bus_rdata;
  logic [15:0] gpio_in = 16'hFFFF;
  logic [15:0] gpio_in_clean;
  logic        irq;

  int tests = 0;
  int fails = 0;

  gpio_edge_irq u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq_ce_i        (irq_ce),
    .bus_we_i        (bus_we),
    .bus_re_i        (bus_re),
    .bus_wdata_i     (bus_wdata),
    .bus_addr_i      (bus_addr),
    .bus_rdata_o     (bus_rdata),
    .gpio_in_i       (gpio_in),
    .gpio_in_clean_o (gpio_in_clean),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [16:0] a, input logic [3:0] we, input logic [31:0] d);
    irq_ce    = 1'b1;
    bus_addr  = a;
    bus_we    = we;
    bus_wdata = d;
    cyc(1);
    irq_ce = 1'b0;
    bus_we = '0;
  endtask

  // Request held two cycles; data sampled in the second.
  task automatic bus_read(input logic [16:0] a, output logic [31:0] d);
    irq_ce   = 1'b1;
    bus_re   = 1'b1;
    bus_addr = a;
    cyc(1);
    d = bus_rdata;
    cyc(1);
    irq_ce = 1'b0;
    bus_re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int ones;
    bit seen;

    vecs[0]  = '{17'h0_0004, 4'b1111, 32'h1234_5678, 32'h1234_5678};
    vecs[1]  = '{17'h1_0007, 4'b0100, 32'hFFAB_FFFF, 32'h12AB_5678};
    vecs[2]  = '{17'h0_0005, 4'b0001, 32'h0000_00C3, 32'h12AB_56C3};
    vecs[3]  = '{17'h0_0004, 4'b0000, 32'hFFFF_FFFF, 32'h12AB_56C3};
    vecs[4]  = '{17'h0_0014, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5]  = '{17'h0_001C, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{17'h0_0008, 4'b1111, 32'hFFFF_FFFF, DbOn ? 32'h00FF_FFFF : 32'h0};
    vecs[7]  = '{17'h0_000C, 4'b1111, 32'hDEAD_BEEF, DbOn ? 32'h0000_BEEF : 32'h0};
    vecs[8]  = '{17'h0_0008, 4'b0011, 32'h0000_0000, DbOn ? 32'h00FF_0000 : 32'h0};
    vecs[9]  = '{17'h0_000C, 4'b0010, 32'h0000_1200, DbOn ? 32'h0000_12EF : 32'h0};
    vecs[10] = '{17'h0_0008, 4'b1111, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{17'h0_000C, 4'b1111, 32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{17'h0_0004, 4'b1111, 32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{17'h0_0000, 4'b0011, 32'h0000_FFFF, 32'h0000_0000};

    // Reset state with all pads high
    cyc(3);
    check("reset_clean", {16'h0, gpio_in_clean}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    cyc(6);
    check("sync_clean_ffff", {16'h0, gpio_in_clean}, 32'h0000_FFFF);
    bus_read(17'h0_0000, rd);
    check("status_after_reset", rd, 32'h0000_FFFF);
    check("irq_after_reset", {31'h0, irq}, 32'h0);
    gpio_in = 16'h0000;
    cyc(5);
    check("clean_zero", {16'h0, gpio_in_clean}, 32'h0);

    // Register write/readback table
    foreach (vecs[i]) begin
      bus_write(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check($sformatf("regvec_%0d", i), rd, vecs[i].exp);
    end

    // Tri-state read bus
    bus_write(17'h0_0004, 4'b1111, 32'hFFFF_FFFF);
    bus_read(17'h0_0004, rd);
    check("edge_all_ones", rd, 32'hFFFF_FFFF);
    irq_ce = 1'b0;
    bus_re = 1'b1;
    #1;
    ones = 0;
    for (int b = 0; b < 32; b++) if (bus_rdata[b] === 1'b1) ones++;
    check("rdata_hiz_ce0", ones, 0);
    irq_ce = 1'b1;
    bus_re = 1'b0;
    #1;
    ones = 0;
    for (int b = 0; b < 32; b++) if (bus_rdata[b] === 1'b1) ones++;
    check("rdata_hiz_re0", ones, 0);
    irq_ce = 1'b0;
    bus_write(17'h0_0004, 4'b1111, 32'h0);

    // Rising edge on pin 0: clean at k+2, irq at k+4
    bus_write(17'h0_0004, 4'b0011, 32'h0000_0001);
    gpio_in[0] = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      cyc(1);
      check($sformatf("rise_clean_j%0d", j), {31'h0, gpio_in_clean[0]}, {31'h0, j >= 2});
      check($sformatf("rise_irq_j%0d", j), {31'h0, irq}, {31'h0, j >= 4});
    end
    bus_read(17'h0_0000, rd);
    check("rise_status", rd, 32'h0001_0001);
    bus_write(17'h0_0000, 4'b1100, 32'h0001_0000);
    check("w1c_irq_still_high", {31'h0, irq}, 32'h1);
    cyc(1);
    check("w1c_irq_low", {31'h0, irq}, 32'h0);
    bus_read(17'h0_0000, rd);
    check("w1c_status", rd, 32'h0000_0001);
    gpio_in[0] = 1'b0;
    cyc(4);

    // Fall on pin 3 coinciding with its W1C: set wins
    bus_write(17'h0_0004, 4'b1100, 32'h0008_0000);
    gpio_in[3] = 1'b1;
    cyc(6);
    gpio_in[3] = 1'b0;
    cyc(3);
    check("fall_clean3", {31'h0, gpio_in_clean[3]}, 32'h0);
    bus_write(17'h0_0000, 4'b1100, 32'h0008_0000);
    bus_read(17'h0_0000, rd);
    check("fall_set_wins", rd, 32'h0008_0000);
    bus_write(17'h0_0004, 4'b1100, 32'h0000_0000);
    bus_read(17'h0_0000, rd);
    check("en_clear_keeps_pending", rd, 32'h0008_0000);
    check("fall_irq", {31'h0, irq}, 32'h1);
    bus_write(17'h0_0000, 4'b1011, 32'hFFFF_FFFF);
    bus_read(17'h0_0000, rd);
    check("w1c_wrong_byte", rd, 32'h0008_0000);
    bus_write(17'h0_0000, 4'b0100, 32'h0008_0000);
    bus_read(17'h0_0000, rd);
    check("w1c_bit3", rd, 32'h0);

    // One-cycle glitch on bypassed pin 2 reaches clean and sets PENDING
    bus_write(17'h0_0004, 4'b1111, 32'h0000_0004);
    gpio_in[2] = 1'b1;
    cyc(1);
    gpio_in[2] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      cyc(1);
      check($sformatf("glitch_clean_j%0d", j), {31'h0, gpio_in_clean[2]}, {31'h0, j == 2});
    end
    bus_read(17'h0_0000, rd);
    check("glitch_pending", rd, 32'h0004_0000);
    bus_write(17'h0_0000, 4'b1100, 32'hFFFF_0000);
    bus_write(17'h0_0004, 4'b1111, 32'h0);

`ifdef GPIO_IRQ_DEBOUNCE_EN
    bus_write(17'h0_0008, 4'b1111, 32'h0004_0002);
    bus_write(17'h0_000C, 4'b1111, 32'h0);
    bus_read(17'h0_0008, rd);
    check("db_cfg", rd, 32'h0004_0002);
    // 3-cycle glitch is filtered
    gpio_in[1] = 1'b1;
    cyc(3);
    gpio_in[1] = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc(1);
      if (gpio_in_clean[1]) seen = 1'b1;
    end
    check("db_glitch_filtered", {31'h0, seen}, 32'h0);
    // 6-cycle high passes after 4 ticks
    gpio_in[1] = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      cyc(1);
      check($sformatf("db_high_j%0d", j), {31'h0, gpio_in_clean[1]}, {31'h0, j >= 5});
      if (j == 5) gpio_in[1] = 1'b0;
    end
    cyc(12);
    check("db_low_again", {31'h0, gpio_in_clean[1]}, 32'h0);
    // PRESCALE=1: tick every other cycle
    bus_write(17'h0_000C, 4'b0011, 32'h0000_0001);
    gpio_in[1] = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      cyc(1);
      check($sformatf("pre_high_j%0d", j), {31'h0, gpio_in_clean[1]}, {31'h0, j >= 9});
    end
    gpio_in[1] = 1'b0;
`else
    bus_write(17'h0_0008, 4'b1111, 32'h0004_0002);
    bus_read(17'h0_0008, rd);
    check("db_absent", rd, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_edge_irq.md
# gpio_edge_irq

Input conditioning and interrupt stage placed between the 16 GPIO pads and the GPIO peripheral's input register. It synchronises the raw pin values, optionally debounces them, and presents clean levels to the GPIO block. It also detects per-pin rising and falling edges, latches them as pending interrupts, and drives a single level interrupt line to the CPU. It has its own chip-select on the shared peripheral bus and uses the same byte-strobe and tri-state read protocol as the GPIO block.

## Interface
- NPINS, 16, number of pins; fixed at 16 for the bus register map
- SYNC_STAGES, 2, synchroniser depth, minimum 2
- CNT_W, 8, width of the debounce threshold and of each per-pin counter
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous and active-low
- irq_ce  in  1  chip select from the address decoder
- bus_we  in  4  byte write enables; bit n covers bus_wdata[8n+7:8n]
- bus_re  in  1  read enable
- bus_wdata  in  32  write data
- bus_addr  in  17  byte address; bits [4:2] select the register, bits [1:0] are ignored
- bus_rdata  out  32  read data; high-Z unless irq_ce and bus_re are both high
- gpio_in  in  16  raw pad values
- gpio_in_clean  out  16  conditioned levels, fed to the GPIO input register
- irq  out  1  level interrupt: OR of pending & 1, registered

## Operation
Register map:
- 0x00 STATUS
  - [15:0] clean levels, read-only
  - [31:16] PENDING, write-1-to-clear through bus_we[3:2]
- 0x04 EDGE_CFG
  - [15:0] RISE_EN, read/write
  - [31:16] FALL_EN, read/write
- 0x08 DEBOUNCE
  - [15:0] DB_MASK, read/write
  - [16+CNT_W-1:16] DB_THRESH, read/write
  - remaining bits read 0
- 0x0C PRESCALE: [15:0] tick divider, read/write; a write also clears the prescaler counter
- Any other offset reads 0; writes to it are ignored.

Bus behaviour:
- Writes occur on a clock edge where irq_ce=1 and bus_we≠0. Only the enabled bytes are updated.
- Reads: rdata_q is registered on every edge where irq_ce=1 and bus_re=1.
- bus_rdata = rdata_q while irq_ce & bus_re is high, otherwise high-Z.

Conditioning, per pin i:
- A SYNC_STAGES flip-flop chain produces sync[i].
- Prescaler counter counts 0..PRESCALE. It asserts `tick` and wraps to 0 when it equals PRESCALE, so PRESCALE=0 gives a tick every cycle.
- Pin in bypass (DB_MASK[i]=0 or DB_THRESH=0): clean[i] <= sync[i] every cycle.
- Pin in debounce:
  - If sync[i]==clean[i], cnt[i] <= 0.
  - Else, on tick: cnt[i]+1 == DB_THRESH sets clean[i] <= sync[i] and cnt[i] <= 0; otherwise cnt[i] increments.
  - Without a tick, cnt[i] holds.
- Edge detect uses clean and clean_d (clean delayed by one cycle):
  - rise = clean & ~clean_d
  - fall = ~clean & clean_d
- Pending update: PENDING[i] <= (PENDING[i] & ~w1c[i]) | (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]). When a set and a W1C hit the same bit in the same cycle, the set wins.
- Clearing an enable bit does not clear its PENDING bit.

Reset:
- All registers, counters, synchroniser stages, clean, clean_d, PENDING and irq are 0.
- rdata_q is 0; bus_rdata is high-Z.
- A pin that is high when reset releases produces a rising edge. Because RISE_EN resets to 0, it does not set PENDING.
- Asserting reset mid-debounce discards the count immediately.

## Timing
- A pad change is captured by the first synchroniser stage at edge k.
- Bypass path: clean updates at edge k+SYNC_STAGES (k+2 by default), PENDING at k+3, irq at k+4.
- Debounce path: clean updates on the DB_THRESH-th consecutive tick with sync≠clean.
- Read: the request is held for two cycles; data is valid from the second cycle.
- W1C: PENDING clears at the write edge; irq falls one edge later.
- A newly written EDGE_CFG applies to edges detected from the next edge on.

## Configuration
- GPIO_IRQ_DEBOUNCE_EN defined: prescaler, per-pin counters, and the DEBOUNCE and PRESCALE registers are present.
- Not defined:
  - All pins are permanently in bypass.
  - 0x08 and 0x0C read 0 and ignore writes.
  - No counter logic is synthesised.

## Structure
- Shared package `gpio_pkg` holds:
  - register offsets: GPIO_IRQ_STATUS_OFS, GPIO_IRQ_EDGE_OFS, GPIO_IRQ_DB_OFS, GPIO_IRQ_PRE_OFS
  - the NPINS constant
  - DB field bit positions
- One sub-module, `gpio_debounce_bit`, per pin, generated NPINS times. It contains cnt, the compare logic and clean. It takes inputs sync, tick, en and thresh.

## Test plan
- Reset state: with gpio_in=0xFFFF held, read 0x00 → 0x0000FFFF after sync; irq stays 0.
- Rise interrupt: write 0x04=0x00000001 with we=0011, toggle gpio_in[0] 0→1 → PENDING=0x0001 and irq=1 four edges after the toggle. Write 0x00=0x00010000 with we=1100 → PENDING=0, irq=0.
- Fall and simultaneous events: FALL_EN[3]=1; issue a W1C of bit 3 on the same edge a new fall is detected → PENDING[3] stays 1.
- Debounce (macro on): DB_MASK=0x0002, DB_THRESH=4, PRESCALE=0. A 3-cycle glitch on pin 1 → clean unchanged. A 6-cycle high on pin 1 → clean[1]=1 after 4 ticks beyond sync.
- Bus protocol: irq_ce=0 with bus_re=1 → bus_rdata==='z. A read of offset 0x14 → 0. A byte write to 0x04 with we=0100 changes only FALL_EN[7:0].
- Macro off: a write of 0x08=0x00040002 followed by a read → 0; a 1-cycle glitch passes through to gpio_in_clean.
